dm_pipe_ctrl: RTL and testbench

Parametrised successor to the single-cycle data memory: a pipelined load/store unit with an internal word array and byte-lane merge. Loads support sign/zero extension; stores are committed with lane merge.
Adds a valid/ready request port, a configurable response latency, and misalignment and out-of-range error detection. It also adds hardware memory clear after reset and a registered store-trace port used by the grading harness.
Sits in the MEM stage; the core stalls on req_ready low and consumes responses in order.

---
 rtl/dm_pipe_ctrl.sv | 170 +++++++++++++++++
 tb/tb_dm_pipe_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dm_pipe_ctrl.sv
// Pipelined load/store unit over an internal word array with byte-lane merge,
// hardware clear after reset, LAT-stage response pipe and a store-trace port.
module dm_pipe_ctrl #(
    parameter int unsigned DEPTH_WORDS    = 4096,
    parameter int unsigned LAT            = 1,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_sel,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  resp_err_code,
    output logic        init_busy,
    output logic        trace_valid,
    output logic [31:0] trace_pc,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_wdata
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {ST_RST, ST_INIT, ST_RUN} state_t;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [1:0]  code;
        logic [31:0] rdata;
    } resp_t;

    state_t        state;
    logic [AW-1:0] clr_cnt;
    logic [31:0]   mem [DEPTH_WORDS];

    logic          accept;
    logic [AW-1:0] idx;
    logic          misaligned;
    logic          out_of_range;
    logic          fault;
    logic [1:0]    err_code;
    logic [31:0]   old_word;
    logic [31:0]   merged;
    logic [31:0]   ext;
    logic [4:0]    byte_sh;
    logic [4:0]    half_sh;
    logic [7:0]    byte_val;
    logic [15:0]   half_val;
    resp_t         resp_in;
    resp_t         stage [LAT];

    assign accept       = req_valid && req_ready;
    assign idx          = req_addr[AW+1:2];
    assign misaligned   = (req_sel[1:0] == 2'b01 && req_addr[0]) ||
                          (req_sel[1] && req_addr[1:0] != 2'b00);
    assign out_of_range = (req_addr[31:2] >= 30'(DEPTH_WORDS));
    assign fault        = misaligned || out_of_range;
    assign err_code     = misaligned ? 2'b01 : (out_of_range ? 2'b10 : 2'b00);
    assign byte_sh      = {req_addr[1:0], 3'b000};
    assign half_sh      = {req_addr[1], 4'b0000};

    always_comb begin
        old_word = mem[idx];
        merged   = old_word;
        byte_val = old_word[byte_sh +: 8];
        half_val = old_word[half_sh +: 16];
        ext      = '0;
        unique case (req_sel[1:0])
            2'b00: begin
                merged[byte_sh +: 8] = req_wdata[7:0];
                ext = {{24{~req_sel[2] & byte_val[7]}}, byte_val};
            end
            2'b01: begin
                merged[half_sh +: 16] = req_wdata[15:0];
                ext = {{16{~req_sel[2] & half_val[15]}}, half_val};
            end
            default: begin
                merged = req_wdata;
                ext    = old_word;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!RESET) begin
            state     <= ST_RST;
            clr_cnt   <= '0;
            req_ready <= 1'b0;
            init_busy <= 1'b0;
        end else begin
            unique case (state)
                ST_RST: begin
                    if (CLEAR_ON_RESET) begin
                        state     <= ST_INIT;
                        init_busy <= 1'b1;
                    end else begin
                        state     <= ST_RUN;
                        req_ready <= 1'b1;
                    end
                end
                ST_INIT: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == AW'(DEPTH_WORDS - 1)) begin
                        state     <= ST_RUN;
                        init_busy <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                ST_RUN:  req_ready <= 1'b1;
                default: state <= ST_RST;
            endcase
        end
    end

    // Clear and store never coincide: req_ready is low throughout INIT.
    always_ff @(posedge clk) begin
        if (RESET) begin
            if (state == ST_INIT)
                mem[clr_cnt] <= '0;
            else if (accept && req_we && !fault)
                mem[idx] <= merged;
        end
    end

    always_comb begin
        resp_in       = '0;
        resp_in.valid = accept;
        resp_in.err   = accept && fault;
        resp_in.code  = accept ? err_code : 2'b00;
        resp_in.rdata = (accept && !req_we && !fault) ? ext : '0;
    end

    always_ff @(posedge clk) begin
        if (!RESET) begin
            for (int unsigned i = 0; i < LAT; i++)
                stage[i] <= '0;
        end else begin
            stage[0] <= resp_in;
            for (int unsigned i = 1; i < LAT; i++)
                stage[i] <= stage[i-1];
        end
    end

    assign resp_valid    = stage[LAT-1].valid;
    assign resp_err      = stage[LAT-1].err;
    assign resp_err_code = stage[LAT-1].code;
    assign resp_rdata    = stage[LAT-1].rdata;

    always_ff @(posedge clk) begin
        if (!RESET) begin
            trace_valid <= 1'b0;
            trace_pc    <= '0;
            trace_addr  <= '0;
            trace_wdata <= '0;
        end else begin
            trace_valid <= accept && req_we && !fault;
            if (accept && req_we && !fault) begin
                trace_pc    <= req_pc;
                trace_addr  <= {req_addr[31:2], 2'b00};
                trace_wdata <= merged;
            end
        end
    end
endmodule

// File: tb/tb_dm_pipe_ctrl.sv
// Randomized bench for dm_pipe_ctrl against a behavioural memory/response model.
module tb_dm_pipe_ctrl;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned LAT   = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_sel;
    logic [31:0] req_addr, req_wdata, req_pc;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err_code;
    logic        init_busy, trace_valid;
    logic [31:0] trace_pc, trace_addr, trace_wdata;

    always #5 clk = ~clk;

    dm_pipe_ctrl #(.DEPTH_WORDS(DEPTH), .LAT(LAT), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .RESET(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_sel(req_sel), .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .resp_err_code(resp_err_code), .init_busy(init_busy),
        .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_addr(trace_addr),
        .trace_wdata(trace_wdata)
    );

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  code;
    } exp_t;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [31:0] mem_m [DEPTH];
    exp_t        q [$];
    bit          in_rst = 1'b1;
    bit          m_ready = 1'b0;
    bit          m_busy = 1'b0;
    int          init_n = 0;
    int          edge_n = 0;
    bit          t_valid;
    logic [31:0] t_pc, t_addr, t_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", tag, got, exp, edge_n);
    endtask

    // One clock: predict the edge from the current inputs, then compare after it.
    task automatic tick();
        exp_t        r;
        exp_t        e;
        bit          acc, mis, oor;
        int          nb, sh, wi;
        logic [31:0] mask, w, v;
        acc     = rst_n && req_valid && m_ready;
        t_valid = 1'b0;
        if (acc) begin
            nb   = (req_sel[1:0] == 2'd0) ? 1 : (req_sel[1:0] == 2'd1) ? 2 : 4;
            sh   = (nb == 1) ? 8 * int'(req_addr[1:0]) : (nb == 2) ? 16 * int'(req_addr[1]) : 0;
            mis  = (nb == 2 && req_addr[0]) || (nb == 4 && req_addr[1:0] != 2'd0);
            oor  = (req_addr >> 2) >= DEPTH;
            mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1) << sh;
            r.due   = edge_n + int'(LAT) - 1;
            r.rdata = '0;
            r.err   = mis || oor;
            r.code  = mis ? 2'd1 : (oor ? 2'd2 : 2'd0);
            if (!r.err) begin
                wi = int'(req_addr >> 2);
                w  = mem_m[wi];
                if (req_we) begin
                    w = (w & ~mask) | ((req_wdata << sh) & mask);
                    mem_m[wi] = w;
                    t_valid = 1'b1;
                    t_pc    = req_pc;
                    t_addr  = req_addr & ~32'd3;
                    t_wdata = w;
                end else begin
                    v = (w & mask) >> sh;
                    if (nb < 4 && !req_sel[2] && v[8*nb-1]) v = v | ~(mask >> sh);
                    r.rdata = v;
                end
            end
            q.push_back(r);
        end
        if (!rst_n) begin
            in_rst = 1'b1; m_ready = 1'b0; m_busy = 1'b0; t_valid = 1'b0;
            q.delete();
        end else if (in_rst) begin
            in_rst = 1'b0; init_n = 0; m_busy = 1'b1; m_ready = 1'b0;
        end else if (m_busy) begin
            init_n++;
            if (init_n == int'(DEPTH)) begin
                m_busy = 1'b0; m_ready = 1'b1;
                for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = '0;
            end
        end
        @(posedge clk);
        #1;
        check("req_ready", req_ready, m_ready);
        check("init_busy", init_busy, m_busy);
        check("trace_valid", trace_valid, t_valid);
        if (t_valid) begin
            check("trace_pc", trace_pc, t_pc);
            check("trace_addr", trace_addr, t_addr);
            check("trace_wdata", trace_wdata, t_wdata);
        end
        if (q.size() > 0 && q[0].due == edge_n) begin
            e = q.pop_front();
            check("resp_valid", resp_valid, 1);
            check("resp_rdata", resp_rdata, e.rdata);
            check("resp_err", resp_err, e.err);
            check("resp_err_code", resp_err_code, e.code);
        end else begin
            check("resp_valid_idle", resp_valid, 0);
            check("resp_rdata_idle", resp_rdata, 0);
            check("resp_err_idle", resp_err, 0);
            check("resp_code_idle", resp_err_code, 0);
        end
        edge_n++;
    endtask

    task automatic issue(input logic we, input logic [2:0] sel, input logic [31:0] addr,
                         input logic [31:0] wdata);
        req_valid = 1'b1; req_we = we; req_sel = sel; req_addr = addr; req_wdata = wdata;
        req_pc = $urandom;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_init();
        int busy_cnt;
        busy_cnt = 0;
        req_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (init_busy) busy_cnt++;
            if (req_ready) break;
        end
        check("init_len", busy_cnt, DEPTH);
        check("ready_after_init", req_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_sel = '0;
        req_addr = '0; req_wdata = '0; req_pc = '0;
        for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = 'x;

        idle(3);
        rst_n = 1'b1;
        wait_init();

        issue(1'b0, 3'b010, 32'h3C, 32'h0);
        issue(1'b1, 3'b010, 32'h10, 32'h1234_5678);
        issue(1'b1, 3'b000, 32'h11, 32'h0000_00AB);
        issue(1'b0, 3'b000, 32'h11, 32'h0);
        issue(1'b0, 3'b100, 32'h11, 32'h0);
        issue(1'b1, 3'b010, 32'h10, 32'h0);
        issue(1'b1, 3'b001, 32'h12, 32'h0000_8001);
        issue(1'b0, 3'b001, 32'h12, 32'h0);
        issue(1'b0, 3'b101, 32'h12, 32'h0);
        issue(1'b1, 3'b001, 32'h13, 32'hFFFF_FFFF);
        issue(1'b0, 3'b010, 32'h42, 32'h0);
        issue(1'b0, 3'b010, 32'h40, 32'h0);
        issue(1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF);
        issue(1'b0, 3'b010, 32'h10, 32'h0);
        idle(LAT);

        issue(1'b1, 3'b010, 32'h0, 32'hCAFE_F00D);
        issue(1'b0, 3'b010, 32'h0, 32'h0);
        idle(LAT + 1);

        issue(1'b0, 3'b010, 32'h10, 32'h0);
        issue(1'b0, 3'b010, 32'h0, 32'h0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        wait_init();
        for (int i = 0; i < int'(DEPTH); i++) issue(1'b0, 3'b010, 32'(i * 4), 32'h0);
        idle(LAT);

        for (int i = 0; i < 800; i++) begin
            rst_n     = ($urandom_range(0, 249) != 0);
            req_valid = ($urandom_range(0, 3) != 0);
            req_we    = $urandom_range(0, 1);
            req_sel   = 3'($urandom_range(0, 7));
            req_addr  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 71));
            req_wdata = $urandom;
            req_pc    = $urandom;
            tick();
        end
        rst_n = 1'b1;
        idle(DEPTH + LAT + 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
